// File: rtl/exec_dispatch.sv
// Single-issue execution unit: mov/add/sub complete in one cycle, mul runs an iterative shift-add.
// Define EXEC_DISPATCH_SAT_EN to saturate overflowing results instead of wrapping.
module exec_dispatch #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [WIDTH-1:0]         in_src1,
    input  logic [WIDTH-1:0]         in_src2,
    input  logic [$clog2(SIZE)-1:0]  in_dst_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(SIZE)-1:0]  out_dst_addr,
    output logic                     out_ovf,
    output logic                     busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a presented result holds steady until taken.

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic               accept;
    logic               mul_last;

    logic [WIDTH:0]     add_full;
    logic [WIDTH-1:0]   fast_data;
    logic               fast_ovf;
    logic [WIDTH-1:0]   mul_data;
    logic               mul_ovf;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign mul_last  = (cnt == CW'(WIDTH - 1));
    // Partial product including this cycle's multiplier bit; on the last step it is the final product.
    assign prod      = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        add_full  = {1'b0, in_src1} + {1'b0, in_src2};
        fast_data = in_src1;
        fast_ovf  = 1'b0;
        case (in_op)
            OP_ADD: begin
                fast_data = add_full[WIDTH-1:0];
                fast_ovf  = add_full[WIDTH];
`ifdef EXEC_DISPATCH_SAT_EN
                if (add_full[WIDTH]) fast_data = '1;
`endif
            end
            OP_SUB: begin
                fast_data = in_src1 - in_src2;
                fast_ovf  = (in_src1 < in_src2);
`ifdef EXEC_DISPATCH_SAT_EN
                if (in_src1 < in_src2) fast_data = '0;
`endif
            end
            default: begin
                fast_data = in_src1;
                fast_ovf  = 1'b0;
            end
        endcase
    end

    always_comb begin
        mul_ovf  = |prod[2*WIDTH-1:WIDTH];
        mul_data = prod[WIDTH-1:0];
`ifdef EXEC_DISPATCH_SAT_EN
        if (mul_ovf) mul_data = '1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = (in_op == OP_MUL) ? MUL : DONE;
            end
            MUL: begin
                if (mul_last) state_next = DONE;
            end
            DONE: begin
                if (accept)         state_next = (in_op == OP_MUL) ? MUL : DONE;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            out_data     <= '0;
            out_dst_addr <= '0;
            out_ovf      <= 1'b0;
        end else if (accept) begin
            out_dst_addr <= in_dst_addr;
            if (in_op == OP_MUL) begin
                mcand  <= {{WIDTH{1'b0}}, in_src1};
                mplier <= in_src2;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                out_data <= fast_data;
                out_ovf  <= fast_ovf;
            end
        end else if (state == MUL) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (mul_last) begin
                out_data <= mul_data;
                out_ovf  <= mul_ovf;
            end
        end
    end

endmodule

// File: tb/tb_exec_dispatch.sv
// Directed and randomized checks of exec_dispatch against an arithmetic reference model.
module tb_exec_dispatch;

    localparam int W    = 8;
    localparam int SIZE = 64;
    localparam int AW   = $clog2(SIZE);

`ifdef EXEC_DISPATCH_SAT_EN
    localparam logic [W-1:0] EXP_ADD_OVF = 8'hFF;
    localparam logic [W-1:0] EXP_SUB_OVF = 8'h00;
    localparam logic [W-1:0] EXP_MUL_OVF = 8'hFF;
`else
    localparam logic [W-1:0] EXP_ADD_OVF = 8'h10;
    localparam logic [W-1:0] EXP_SUB_OVF = 8'hFE;
    localparam logic [W-1:0] EXP_MUL_OVF = 8'h00;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_src1;
    logic [W-1:0]  in_src2;
    logic [AW-1:0] in_dst_addr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_dst_addr;
    logic          out_ovf;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Entry layout: {addr, ovf, data}
    logic [AW+W:0] exp_q[$];

    exec_dispatch #(.WIDTH(W), .SIZE(SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_src1      (in_src1),
        .in_src2      (in_src2),
        .in_dst_addr  (in_dst_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_dst_addr (out_dst_addr),
        .out_ovf      (out_ovf),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for a single cycle from IDLE; returns one cycle after acceptance.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] addr);
        in_valid    = 1'b1;
        in_op       = op;
        in_src1     = a;
        in_src2     = b;
        in_dst_addr = addr;
        cyc();
        in_valid    = 1'b0;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    // Cycles from acceptance until out_valid is seen (caller is one cycle past acceptance).
    task automatic wait_valid(output int n);
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
    endtask

    function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        int unsigned ua, ub, r, lim;
        logic ovf;
        ua  = a;
        ub  = b;
        lim = 1 << W;
        case (op)
            2'b00: begin r = ua; ovf = 1'b0; end
            2'b01: begin r = ua * ub; ovf = (r >= lim); end
            2'b10: begin r = ua + ub; ovf = (r >= lim); end
            default: begin r = ua + lim - ub; ovf = (ua < ub); end
        endcase
        r = r % lim;
`ifdef EXEC_DISPATCH_SAT_EN
        if (ovf) r = (op == 2'b11) ? 0 : lim - 1;
`endif
        return {ovf, W'(r)};
    endfunction

    task automatic compare_head(input string tag);
        logic [AW+W:0] e;
        check({tag, "_has_exp"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(out_data), 32'(e[W-1:0]));
            check({tag, "_ovf"},  32'(out_ovf),  32'(e[W]));
            check({tag, "_addr"}, 32'(out_dst_addr), 32'(e[AW+W:W+1]));
        end
    endtask

    initial begin
        int n;
        int seen;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_op       = 2'b00;
        in_src1     = '0;
        in_src2     = '0;
        in_dst_addr = '0;
        out_ready   = 1'b0;

        // Reset state
        cyc();
        cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_addr",  32'(out_dst_addr), 32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        rst_n = 1'b1;
        cyc();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // add 0x30 + 0x25 -> 0x55 at addr 9, one cycle latency
        issue(2'b10, 8'h30, 8'h25, 6'd9);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_data",  32'(out_data),  32'h55);
        check("add_ovf",   32'(out_ovf),   32'd0);
        check("add_addr",  32'(out_dst_addr), 32'd9);
        check("add_busy",  32'(busy),      32'd1);
        retire();
        check("add_idle_valid", 32'(out_valid), 32'd0);
        check("add_idle_busy",  32'(busy),      32'd0);

        // Carry and borrow
        issue(2'b10, 8'hF0, 8'h20, 6'd1);
        check("add_carry_data", 32'(out_data), 32'(EXP_ADD_OVF));
        check("add_carry_ovf",  32'(out_ovf),  32'd1);
        retire();
        issue(2'b11, 8'h05, 8'h07, 6'd2);
        check("sub_borrow_data", 32'(out_data), 32'(EXP_SUB_OVF));
        check("sub_borrow_ovf",  32'(out_ovf),  32'd1);
        retire();

        // mul latency; in_valid during MUL/stalled DONE must be ignored
        issue(2'b01, 8'h0C, 8'h0B, 6'd12);
        check("mul_in_ready_low", 32'(in_ready), 32'd0);
        check("mul_busy",         32'(busy),     32'd1);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_src1  = 8'h77;
        wait_valid(n);
        in_valid = 1'b0;
        check("mul_latency", 32'(n), 32'd9);
        check("mul_data",    32'(out_data), 32'h84);
        check("mul_ovf",     32'(out_ovf),  32'd0);
        check("mul_addr",    32'(out_dst_addr), 32'd12);
        retire();
        issue(2'b01, 8'h10, 8'h10, 6'd13);
        wait_valid(n);
        check("mul_ovf_latency", 32'(n), 32'd9);
        check("mul_ovf_data",    32'(out_data), 32'(EXP_MUL_OVF));
        check("mul_ovf_flag",    32'(out_ovf),  32'd1);
        retire();

        // Stall in DONE for 5 cycles, then back-to-back mov
        issue(2'b10, 8'h01, 8'h02, 6'd3);
        in_valid    = 1'b1;
        in_op       = 2'b00;
        in_src1     = 8'hA5;
        in_src2     = 8'h00;
        in_dst_addr = 6'd7;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_data",     32'(out_data),  32'h03);
            check("stall_addr",     32'(out_dst_addr), 32'd3);
            check("stall_in_ready", 32'(in_ready),  32'd0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_data",  32'(out_data),  32'hA5);
        check("b2b_addr",  32'(out_dst_addr), 32'd7);
        cyc();
        out_ready = 1'b0;
        check("b2b_idle", 32'(out_valid), 32'd0);

        // Reset in the 4th MUL cycle discards the result
        issue(2'b01, 8'h33, 8'h05, 6'd20);
        cyc();
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy",  32'(busy),      32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid === 1'b1) seen++;
            cyc();
        end
        check("midrst_no_result", 32'(seen), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_op       = 2'($urandom_range(0, 3));
            in_src1     = W'($urandom_range(0, (1 << W) - 1));
            in_src2     = W'($urandom_range(0, (1 << W) - 1));
            in_dst_addr = AW'($urandom_range(0, SIZE - 1));
            out_ready   = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid === 1'b1 && out_ready) compare_head("rand");
            if (in_valid && in_ready === 1'b1)
                exp_q.push_back({in_dst_addr, model(in_op, in_src1, in_src2)});
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
            if (out_valid === 1'b1) compare_head("drain");
            cyc();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
